// File: rtl/redirect_flush_sequencer_pkg.sv
// Shared definitions for the redirect/flush sequencer and for other blocks
// that need ROB-relative age comparison (ROB, branch-tag logic).
//   state_t    : sequencer FSM states
//   SRC_*      : RedirSrc encoding
//   ROBID_W    : ROB id width including the wrap bit
//   age_older  : true when id_a is strictly older than id_b relative to head
package redirect_flush_sequencer_pkg;

  localparam int ROBID_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_RESUME = 2'd3
  } state_t;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_ROB  = 2'd1;
  localparam logic [1:0] SRC_BRU  = 2'd2;
  localparam logic [1:0] SRC_PRE  = 2'd3;

  // Age is the distance from the head, modulo the id space, so ids that have
  // wrapped past the head still order correctly. Equal age is not older.
  function automatic logic age_older(input logic [ROBID_W-1:0] id_a,
                                     input logic [ROBID_W-1:0] id_b,
                                     input logic [ROBID_W-1:0] head);
    logic [ROBID_W-1:0] age_a;
    logic [ROBID_W-1:0] age_b;
    age_a = id_a - head;
    age_b = id_b - head;
    return age_a < age_b;
  endfunction

endpackage

// File: rtl/redir_age_cmp.sv
// Combinational ROB age comparator.
//   id_a, id_b : ROB ids to compare (W bits, including wrap bit)
//   head       : current ROB head, the age base
//   is_older   : 1 when id_a is strictly older than id_b
module redir_age_cmp
  import redirect_flush_sequencer_pkg::*;
#(
  parameter int W = redirect_flush_sequencer_pkg::ROBID_W
) (
  input  logic [W-1:0] id_a,
  input  logic [W-1:0] id_b,
  input  logic [W-1:0] head,
  output logic         is_older
);

  logic [W-1:0] age_a;
  logic [W-1:0] age_b;

  always_comb begin
    age_a    = id_a - head;
    age_b    = id_b - head;
    is_older = (age_a < age_b);
  end

endmodule

// File: rtl/redirect_flush_sequencer.sv
// Central redirect arbiter and flush sequencer.
// Picks one redirect among ROB > BRU > PRE, then runs flush -> drain -> resume
// and issues a single one-cycle redirect pulse to PC generation. Higher
// priority (or older BRU) requests preempt an in-flight sequence.
//
// Ports:
//   Clk, Rest                     : clock, synchronous active-high reset
//   RobRedirValid/RobRedirPc      : ROB redirect (exception/ertn)
//   BruRedirValid/Pc/RobId        : branch mispredict redirect
//   PreRedirValid/PreRedirPc      : predecoder redirect
//   RobHeadId                     : ROB head, base for BRU age compare
//   FrontQuiet                    : frontend has drained
//   FrontFlush, BackFlush         : pipeline flush controls
//   FrontHold                     : freeze PC/predictor advance
//   RedirValid, RedirPc, RedirSrc : redirect pulse, target and winner source
//   Busy                          : sequence in progress
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no redirect in flight
// ST_FLUSH  | flushes asserted for FLUSH_CYC cycles (counter counts down)
// ST_DRAIN  | frontend held until FrontQuiet
// ST_RESUME | one-cycle RedirValid pulse with the latched target
module redirect_flush_sequencer
  import redirect_flush_sequencer_pkg::*;
#(
  parameter int PC_W      = 32,
  parameter int ROBID_W   = redirect_flush_sequencer_pkg::ROBID_W,
  parameter int FLUSH_CYC = 2
) (
  input  logic               Clk,
  input  logic               Rest,
  input  logic               RobRedirValid,
  input  logic [PC_W-1:0]    RobRedirPc,
  input  logic               BruRedirValid,
  input  logic [PC_W-1:0]    BruRedirPc,
  input  logic [ROBID_W-1:0] BruRedirRobId,
  input  logic               PreRedirValid,
  input  logic [PC_W-1:0]    PreRedirPc,
  input  logic [ROBID_W-1:0] RobHeadId,
  input  logic               FrontQuiet,
  output logic               FrontFlush,
  output logic               BackFlush,
  output logic               FrontHold,
  output logic               RedirValid,
  output logic [PC_W-1:0]    RedirPc,
  output logic [1:0]         RedirSrc,
  output logic               Busy
);

  localparam int CNT_W = $clog2(FLUSH_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYC - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PC_W-1:0]      lat_pc_q, lat_pc_d;
  logic [1:0]           lat_src_q, lat_src_d;
  logic [ROBID_W-1:0]   lat_id_q, lat_id_d;
  logic [PC_W-1:0]      redir_pc_q, redir_pc_d;

  logic                 bru_older;
  logic                 load;
  logic [1:0]           new_src;
  logic [PC_W-1:0]      new_pc;

  redir_age_cmp #(.W(ROBID_W)) u_age_cmp (
    .id_a     (BruRedirRobId),
    .id_b     (lat_id_q),
    .head     (RobHeadId),
    .is_older (bru_older)
  );

  always_ff @(posedge Clk) begin
    if (Rest) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      lat_pc_q   <= '0;
      lat_src_q  <= SRC_NONE;
      lat_id_q   <= '0;
      redir_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_pc_q   <= lat_pc_d;
      lat_src_q  <= lat_src_d;
      lat_id_q   <= lat_id_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_pc_d   = lat_pc_q;
    lat_src_d  = lat_src_q;
    lat_id_d   = lat_id_q;
    redir_pc_d = redir_pc_q;
    load       = 1'b0;
    new_src    = SRC_NONE;
    new_pc     = '0;

    if (state_q == ST_IDLE) begin
      if (RobRedirValid) begin
        load = 1'b1; new_src = SRC_ROB; new_pc = RobRedirPc;
      end else if (BruRedirValid) begin
        load = 1'b1; new_src = SRC_BRU; new_pc = BruRedirPc;
      end else if (PreRedirValid) begin
        load = 1'b1; new_src = SRC_PRE; new_pc = PreRedirPc;
      end
    end else begin
      // While busy, any ROB request wins (a newer ROB target replaces an
      // older one); BRU only displaces PRE or a younger BRU; PRE is dropped.
      if (RobRedirValid) begin
        load = 1'b1; new_src = SRC_ROB; new_pc = RobRedirPc;
      end else if (BruRedirValid &&
                   ((lat_src_q == SRC_PRE) ||
                    ((lat_src_q == SRC_BRU) && bru_older))) begin
        load = 1'b1; new_src = SRC_BRU; new_pc = BruRedirPc;
      end
    end

    if (load) begin
      state_d   = ST_FLUSH;
      cnt_d     = CNT_LOAD;
      lat_pc_d  = new_pc;
      lat_src_d = new_src;
      if (new_src == SRC_BRU) lat_id_d = BruRedirRobId;
    end else begin
      case (state_q)
        ST_FLUSH: begin
          if (cnt_q == '0) state_d = ST_DRAIN;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        ST_DRAIN: begin
          if (FrontQuiet) begin
            state_d    = ST_RESUME;
            redir_pc_d = lat_pc_q;
          end
        end
        ST_RESUME: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // All outputs decode registered state only.
  assign FrontFlush = (state_q == ST_FLUSH);
  assign BackFlush  = (state_q == ST_FLUSH) &&
                      ((lat_src_q == SRC_ROB) || (lat_src_q == SRC_BRU));
  assign FrontHold  = (state_q == ST_FLUSH) || (state_q == ST_DRAIN);
  assign RedirValid = (state_q == ST_RESUME);
  assign RedirPc    = redir_pc_q;
  assign Busy       = (state_q != ST_IDLE);
  assign RedirSrc   = Busy ? lat_src_q : SRC_NONE;

endmodule

// File: tb/tb_redirect_flush_sequencer.sv
module tb_redirect_flush_sequencer;

  logic        Clk = 1'b0;
  logic        Rest;
  logic        RobRedirValid;
  logic [31:0] RobRedirPc;
  logic        BruRedirValid;
  logic [31:0] BruRedirPc;
  logic [5:0]  BruRedirRobId;
  logic        PreRedirValid;
  logic [31:0] PreRedirPc;
  logic [5:0]  RobHeadId;
  logic        FrontQuiet;
  logic        FrontFlush;
  logic        BackFlush;
  logic        FrontHold;
  logic        RedirValid;
  logic [31:0] RedirPc;
  logic [1:0]  RedirSrc;
  logic        Busy;

  int errors = 0;
  int checks = 0;

  redirect_flush_sequencer #(.PC_W(32), .ROBID_W(6), .FLUSH_CYC(2)) dut (
    .Clk           (Clk),
    .Rest          (Rest),
    .RobRedirValid (RobRedirValid),
    .RobRedirPc    (RobRedirPc),
    .BruRedirValid (BruRedirValid),
    .BruRedirPc    (BruRedirPc),
    .BruRedirRobId (BruRedirRobId),
    .PreRedirValid (PreRedirValid),
    .PreRedirPc    (PreRedirPc),
    .RobHeadId     (RobHeadId),
    .FrontQuiet    (FrontQuiet),
    .FrontFlush    (FrontFlush),
    .BackFlush     (BackFlush),
    .FrontHold     (FrontHold),
    .RedirValid    (RedirValid),
    .RedirPc       (RedirPc),
    .RedirSrc      (RedirSrc),
    .Busy          (Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst;
    logic        rob_v;
    logic [31:0] rob_pc;
    logic        bru_v;
    logic [31:0] bru_pc;
    logic [5:0]  bru_id;
    logic        pre_v;
    logic [31:0] pre_pc;
    logic [5:0]  head;
    logic        quiet;
    logic        ff;
    logic        bf;
    logic        fh;
    logic        rv;
    logic        chk_pc;
    logic [31:0] rpc;
    logic [1:0]  src;
    logic        busy;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr();
    Rest = 1'b0;
    RobRedirValid = 1'b0; RobRedirPc = '0;
    BruRedirValid = 1'b0; BruRedirPc = '0; BruRedirRobId = '0;
    PreRedirValid = 1'b0; PreRedirPc = '0;
    RobHeadId = '0;
    FrontQuiet = 1'b1;
  endtask

  task automatic expect_o(input string tag, input logic ff, input logic bf, input logic fh,
                          input logic rv, input logic [1:0] src, input logic busy);
    chk({tag, " FrontFlush"}, 32'(FrontFlush), 32'(ff));
    chk({tag, " BackFlush"},  32'(BackFlush),  32'(bf));
    chk({tag, " FrontHold"},  32'(FrontHold),  32'(fh));
    chk({tag, " RedirValid"}, 32'(RedirValid), 32'(rv));
    chk({tag, " RedirSrc"},   32'(RedirSrc),   32'(src));
    chk({tag, " Busy"},       32'(Busy),       32'(busy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst rob_v rob_pc bru_v bru_pc bru_id pre_v pre_pc head quiet | ff bf fh rv chk_pc rpc src busy
    vecs[0]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b1,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 2'd0, 1'b0};
    // PRE request: 2 flush cycles, no back flush, pulse at t+4
    vecs[1]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 6'd0, 1'b1, 32'h1c000100, 6'd0, 1'b1,
                 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd3, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b1,
                 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd3, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b1,
                 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd3, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b1,
                 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1c000100, 2'd3, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b1,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0};
    // ROB/BRU tie: ROB wins; PRE and BRU while ROB latched are dropped
    vecs[6]  = '{1'b0, 1'b1, 32'h1c008000, 1'b1, 32'h1c000200, 6'd5, 1'b0, 32'h0, 6'd0, 1'b1,
                 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2'd1, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 6'd0, 1'b1, 32'h1c00dead, 6'd0, 1'b1,
                 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2'd1, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h1c000300, 6'd2, 1'b0, 32'h0, 6'd0, 1'b1,
                 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd1, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b1,
                 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1c008000, 2'd1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b1,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0};
    // PRE latched, then BRU preempts and restarts the flush count
    vecs[11] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 6'd0, 1'b1, 32'h1c000400, 6'd0, 1'b1,
                 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd3, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h1c000500, 6'd7, 1'b0, 32'h0, 6'd0, 1'b1,
                 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2'd2, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b1,
                 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2'd2, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b1,
                 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd2, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b1,
                 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1c000500, 2'd2, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b1,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0};

    clr();
    for (int i = 0; i < NVEC; i++) begin
      Rest          = vecs[i].rst;
      RobRedirValid = vecs[i].rob_v;
      RobRedirPc    = vecs[i].rob_pc;
      BruRedirValid = vecs[i].bru_v;
      BruRedirPc    = vecs[i].bru_pc;
      BruRedirRobId = vecs[i].bru_id;
      PreRedirValid = vecs[i].pre_v;
      PreRedirPc    = vecs[i].pre_pc;
      RobHeadId     = vecs[i].head;
      FrontQuiet    = vecs[i].quiet;
      step();
      expect_o($sformatf("v%0d", i), vecs[i].ff, vecs[i].bf, vecs[i].fh,
               vecs[i].rv, vecs[i].src, vecs[i].busy);
      if (vecs[i].chk_pc) chk($sformatf("v%0d RedirPc", i), RedirPc, vecs[i].rpc);
    end

    // Age with wrap, head=60: id 62 (age 2) latched, id 1 (age 5) must not preempt
    clr();
    RobHeadId = 6'd60;
    BruRedirValid = 1'b1; BruRedirRobId = 6'd62; BruRedirPc = 32'h1c001000;
    step(); expect_o("ageA f1", 1, 1, 1, 0, 2'd2, 1);
    BruRedirRobId = 6'd1; BruRedirPc = 32'h1c002000;
    step(); expect_o("ageA f2", 1, 1, 1, 0, 2'd2, 1);
    BruRedirValid = 1'b0;
    step(); expect_o("ageA drain", 0, 0, 1, 0, 2'd2, 1);
    step(); expect_o("ageA resume", 0, 0, 0, 1, 2'd2, 1);
    chk("ageA RedirPc", RedirPc, 32'h1c001000);
    step(); expect_o("ageA idle", 0, 0, 0, 0, 2'd0, 0);

    // Reverse order: id 62 arrives second, is older, restarts the flush
    BruRedirValid = 1'b1; BruRedirRobId = 6'd1; BruRedirPc = 32'h1c002000;
    step(); expect_o("ageB f1", 1, 1, 1, 0, 2'd2, 1);
    BruRedirRobId = 6'd62; BruRedirPc = 32'h1c001000;
    step(); expect_o("ageB f2", 1, 1, 1, 0, 2'd2, 1);
    BruRedirValid = 1'b0;
    step(); expect_o("ageB f3 restart", 1, 1, 1, 0, 2'd2, 1);
    step(); expect_o("ageB drain", 0, 0, 1, 0, 2'd2, 1);
    step(); expect_o("ageB resume", 0, 0, 0, 1, 2'd2, 1);
    chk("ageB RedirPc", RedirPc, 32'h1c001000);
    step(); expect_o("ageB idle", 0, 0, 0, 0, 2'd0, 0);

    // Drain stall: FrontQuiet low for 10 DRAIN cycles
    clr();
    FrontQuiet = 1'b0;
    PreRedirValid = 1'b1; PreRedirPc = 32'h1c003000;
    step(); expect_o("stall f1", 1, 0, 1, 0, 2'd3, 1);
    PreRedirValid = 1'b0;
    step(); expect_o("stall f2", 1, 0, 1, 0, 2'd3, 1);
    step(); expect_o("stall d0", 0, 0, 1, 0, 2'd3, 1);
    for (int k = 0; k < 10; k++) begin
      step(); expect_o($sformatf("stall d%0d", k + 1), 0, 0, 1, 0, 2'd3, 1);
    end
    FrontQuiet = 1'b1;
    step(); expect_o("stall resume", 0, 0, 0, 1, 2'd3, 1);
    chk("stall RedirPc", RedirPc, 32'h1c003000);
    step(); expect_o("stall idle", 0, 0, 0, 0, 2'd0, 0);

    // ROB arrives on the last DRAIN cycle with BRU latched: pulse suppressed
    clr();
    BruRedirValid = 1'b1; BruRedirRobId = 6'd3; BruRedirPc = 32'h1c004000;
    step(); expect_o("pd f1", 1, 1, 1, 0, 2'd2, 1);
    BruRedirValid = 1'b0;
    step(); expect_o("pd f2", 1, 1, 1, 0, 2'd2, 1);
    step(); expect_o("pd drain", 0, 0, 1, 0, 2'd2, 1);
    RobRedirValid = 1'b1; RobRedirPc = 32'h1c009000;
    step(); expect_o("pd preempt", 1, 1, 1, 0, 2'd1, 1);
    RobRedirValid = 1'b0;
    step(); expect_o("pd f2b", 1, 1, 1, 0, 2'd1, 1);
    step(); expect_o("pd drain2", 0, 0, 1, 0, 2'd1, 1);
    step(); expect_o("pd resume", 0, 0, 0, 1, 2'd1, 1);
    chk("pd RedirPc", RedirPc, 32'h1c009000);
    step(); expect_o("pd idle", 0, 0, 0, 0, 2'd0, 0);

    // ROB arrives during RESUME with BRU latched: sequence restarts with ROB
    BruRedirValid = 1'b1; BruRedirRobId = 6'd3; BruRedirPc = 32'h1c004000;
    step(); expect_o("pr f1", 1, 1, 1, 0, 2'd2, 1);
    BruRedirValid = 1'b0;
    step(); expect_o("pr f2", 1, 1, 1, 0, 2'd2, 1);
    step(); expect_o("pr drain", 0, 0, 1, 0, 2'd2, 1);
    step(); expect_o("pr resume", 0, 0, 0, 1, 2'd2, 1);
    RobRedirValid = 1'b1; RobRedirPc = 32'h1c00a000;
    step(); expect_o("pr restart", 1, 1, 1, 0, 2'd1, 1);
    RobRedirValid = 1'b0;
    step(); expect_o("pr f2b", 1, 1, 1, 0, 2'd1, 1);
    step(); expect_o("pr drain2", 0, 0, 1, 0, 2'd1, 1);
    step(); expect_o("pr resume2", 0, 0, 0, 1, 2'd1, 1);
    chk("pr RedirPc", RedirPc, 32'h1c00a000);
    step(); expect_o("pr idle", 0, 0, 0, 0, 2'd0, 0);

    // Reset mid-DRAIN aborts with no later pulse
    clr();
    FrontQuiet = 1'b0;
    PreRedirValid = 1'b1; PreRedirPc = 32'h1c005000;
    step(); expect_o("rst f1", 1, 0, 1, 0, 2'd3, 1);
    PreRedirValid = 1'b0;
    step();
    step(); expect_o("rst drain", 0, 0, 1, 0, 2'd3, 1);
    Rest = 1'b1;
    step(); expect_o("rst applied", 0, 0, 0, 0, 2'd0, 0);
    chk("rst RedirPc", RedirPc, 32'h0);
    Rest = 1'b0; FrontQuiet = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("rst after%0d RedirValid", k), 32'(RedirValid), 32'h0);
      chk($sformatf("rst after%0d Busy", k), 32'(Busy), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
